// File: rtl/piso_pkg.sv
// ----------------------------------------------------------------------------
// piso_pkg : shared types and constants for the shift-left serial link
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package piso_pkg;

  localparam int WIDTH_DEFAULT = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_left_piso_if.sv
// ----------------------------------------------------------------------------
// shift_left_piso_if : load handshake and serial-side signals of the PISO
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface shift_left_piso_if #(
  parameter int WIDTH = piso_pkg::WIDTH_DEFAULT
);

  logic             load_valid;
  logic [WIDTH-1:0] parallel_data_in;
  logic             load_ready;
  logic             shift_en;
  logic             serial_data_out;
  logic             serial_valid;
  logic             frame_done;

  // Producer / pacing side
  modport master (
    output load_valid,
    output parallel_data_in,
    output shift_en,
    input  load_ready,
    input  serial_data_out,
    input  serial_valid,
    input  frame_done
  );

  // Transmitter side
  modport slave (
    input  load_valid,
    input  parallel_data_in,
    input  shift_en,
    output load_ready,
    output serial_data_out,
    output serial_valid,
    output frame_done
  );

endinterface

`default_nettype wire

// File: rtl/shift_left_piso.sv
// ----------------------------------------------------------------------------
// shift_left_piso : parallel-in serial-out transmitter, MSB first
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shift_left_piso
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  wire logic          clk,
  input  wire logic          reset,
  shift_left_piso_if.slave   bus
);

  localparam int               CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   shreg_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_nxt;
  logic               last_bit;
  logic               accept;

  assign last_bit = (state == S_SHIFT) && (bit_cnt == LAST) && bus.shift_en;
  // Ready in the last-bit cycle lets a new word follow with no idle gap.
  assign bus.load_ready = reset && ((state == S_IDLE) || last_bit);
  assign accept         = bus.load_valid && bus.load_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    if (accept) begin
      state_nxt   = S_SHIFT;
      shreg_nxt   = bus.parallel_data_in;
      bit_cnt_nxt = '0;
    end else if (state == S_SHIFT && bus.shift_en) begin
      shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
      if (bit_cnt == LAST) begin
        state_nxt   = S_IDLE;
        bit_cnt_nxt = '0;
      end else begin
        bit_cnt_nxt = bit_cnt + 1'b1;
      end
    end
  end

  assign bus.serial_data_out = (state == S_SHIFT) ? shreg[WIDTH-1] : 1'b0;
  assign bus.serial_valid    = (state == S_SHIFT);
  assign bus.frame_done      = last_bit;

endmodule

`default_nettype wire

// File: tb/tb_shift_left_piso.sv
// ----------------------------------------------------------------------------
// tb_shift_left_piso : directed and randomized loopback bench for the PISO
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_shift_left_piso;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  shift_left_piso_if #(.WIDTH(WIDTH)) bus ();

  shift_left_piso #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shift-left SIPO receiver on the falling edge, paced by the same enable.
  logic [WIDTH-1:0] sipo;
  always @(negedge clk) begin
    if (bus.serial_valid && bus.shift_en)
      sipo <= {sipo[WIDTH-2:0], bus.serial_data_out};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [WIDTH-1:0] w);
    bus.load_valid       = 1'b1;
    bus.parallel_data_in = w;
    next_cycle();
    bus.load_valid       = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] got;
    reset                = 1'b0;
    bus.load_valid       = 1'b0;
    bus.parallel_data_in = '0;
    bus.shift_en         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
    n_checks++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: {sdo,sv,fd,lr} got %b expected 0000", got);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_release: {sdo,sv,fd,lr} got %b expected 0001", got);
    end
    next_cycle();
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] w;
    logic [3:0]       got;
    logic [3:0]       exp;
    w = 4'b1011;
    bus.shift_en = 1'b1;
    load_word(w);
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
      exp = {w[WIDTH-1-k], 1'b1, (k == WIDTH-1), (k == WIDTH-1)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single bit %0d: {sdo,sv,fd,lr} got %b expected %b", k, got, exp);
      end
      next_cycle();
    end
    @(negedge clk);
    got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL single idle: {sdo,sv,fd,lr} got %b expected 0001", got);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_ser;
    logic [3:0] got;
    logic [3:0] exp;
    exp_ser = 8'b1011_0110;
    bus.shift_en = 1'b1;
    load_word(4'b1011);
    for (int c = 0; c < 8; c++) begin
      bus.load_valid       = (c == 3);
      bus.parallel_data_in = 4'b0110;
      @(negedge clk);
      got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
      exp = {exp_ser[7-c], 1'b1, (c == 3 || c == 7), (c == 3 || c == 7)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: {sdo,sv,fd,lr} got %b expected %b", c, got, exp);
      end
      next_cycle();
    end
    bus.load_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.serial_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back idle: serial_valid got %b expected 0", bus.serial_valid);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    logic [6:0] exp_ser;
    logic [6:0] en_pat;
    logic [3:0] got;
    logic [3:0] exp;
    exp_ser = 7'b1111100;
    en_pat  = 7'b1000111;
    bus.shift_en = 1'b1;
    load_word(4'b1100);
    for (int c = 0; c < 7; c++) begin
      bus.shift_en = en_pat[6-c];
      @(negedge clk);
      got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
      exp = {exp_ser[6-c], 1'b1, (c == 6), (c == 6)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stall cycle %0d: {sdo,sv,fd,lr} got %b expected %b", c, got, exp);
      end
      next_cycle();
    end
    bus.shift_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.serial_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall idle: serial_valid got %b expected 0", bus.serial_valid);
    end
    next_cycle();
  endtask

  task automatic test_ignore_busy();
    logic [7:0] exp_ser;
    logic [3:0] got;
    logic [3:0] exp;
    exp_ser = 8'b1001_1111;
    bus.shift_en = 1'b1;
    load_word(4'b1001);
    for (int c = 0; c < 8; c++) begin
      bus.load_valid       = (c <= 3);
      bus.parallel_data_in = 4'b1111;
      @(negedge clk);
      got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
      exp = {exp_ser[7-c], 1'b1, (c == 3 || c == 7), (c == 3 || c == 7)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ignore_busy cycle %0d: {sdo,sv,fd,lr} got %b expected %b", c, got, exp);
      end
      next_cycle();
    end
    bus.load_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_midframe();
    logic [WIDTH-1:0] w;
    logic [3:0]       got;
    logic [3:0]       exp;
    bus.shift_en = 1'b1;
    w = 4'b1010;
    load_word(w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.serial_data_out !== w[WIDTH-1-k]) begin
        n_fail++;
        $display("FAIL abort_pre bit %0d: sdo got %b expected %b", k, bus.serial_data_out, w[WIDTH-1-k]);
      end
      next_cycle();
    end
    // Last-bit cycle: reset lands between edges and must act at once.
    #2;
    reset = 1'b0;
    #1;
    got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
    n_checks++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_async: {sdo,sv,fd,lr} got %b expected 0000", got);
    end
    @(negedge clk);
    got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
    n_checks++;
    if (got !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_held: {sdo,sv,fd,lr} got %b expected 0000", got);
    end
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
    n_checks++;
    if (got !== 4'b0001) begin
      n_fail++;
      $display("FAIL abort_release: {sdo,sv,fd,lr} got %b expected 0001", got);
    end
    next_cycle();
    w = 4'b0101;
    load_word(w);
    for (int k = 0; k < WIDTH; k++) begin
      @(negedge clk);
      got = {bus.serial_data_out, bus.serial_valid, bus.frame_done, bus.load_ready};
      exp = {w[WIDTH-1-k], 1'b1, (k == WIDTH-1), (k == WIDTH-1)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL abort_resend bit %0d: {sdo,sv,fd,lr} got %b expected %b", k, got, exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_loopback_random();
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_w;
    int               frames;
    int               sent;
    int               cyc;
    bit               accepted;
    bit               pending_fd;
    frames     = 0;
    sent       = 0;
    cyc        = 0;
    accepted   = 1'b0;
    pending_fd = 1'b0;
    bus.load_valid = 1'b0;
    bus.shift_en   = 1'b1;
    while (frames < 16 && cyc < 2000) begin
      if (pending_fd) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL loopback: frame_done with no word outstanding, sipo got %b", sipo);
        end else begin
          exp_w = q.pop_front();
          if (sipo !== exp_w) begin
            n_fail++;
            $display("FAIL loopback frame %0d: sipo got %b expected %b", frames, sipo, exp_w);
          end
        end
        frames++;
      end
      if (accepted) begin
        q.push_back(bus.parallel_data_in);
        sent++;
        bus.load_valid = 1'b0;
      end
      if (!bus.load_valid && sent < 16 && $urandom_range(0, 2) != 0) begin
        bus.load_valid       = 1'b1;
        bus.parallel_data_in = WIDTH'($urandom);
      end
      bus.shift_en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      accepted   = bus.load_valid && bus.load_ready;
      pending_fd = bus.frame_done;
      next_cycle();
      cyc++;
    end
    bus.load_valid = 1'b0;
    bus.shift_en   = 1'b1;
    n_checks++;
    if (frames != 16) begin
      n_fail++;
      $display("FAIL loopback_count: frames got %0d expected 16 within cycle budget", frames);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_ignore_busy();
    test_reset_midframe();
    test_loopback_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
